// File: rtl/mesh_torus_lkh_route_pipe_pkg.sv
// Shared definitions for the look-ahead route pipeline and the next-hop block.
//   - port encoding (LOCAL, EAST, NORTH, WEST, SOUTH), 3-bit binary
//   - topology codes (mesh/torus) and dimension-order codes (XY/YX)
//   - log2: coordinate width for a router count (minimum 1 bit)
package mesh_torus_lkh_route_pipe_pkg;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_EAST  = 3'd1;
  localparam logic [2:0] PORT_NORTH = 3'd2;
  localparam logic [2:0] PORT_WEST  = 3'd3;
  localparam logic [2:0] PORT_SOUTH = 3'd4;

  localparam int TOPO_MESH  = 0;
  localparam int TOPO_TORUS = 1;

  localparam int ROUTE_XY = 0;
  localparam int ROUTE_YX = 1;

  // Ceiling log2 with a floor of one bit so a 1-wide dimension still has a port.
  function automatic int log2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mesh_torus_lkh_route_pipe_next_hop.sv
// mesh_torus_next_hop: combinational coordinate update for one hop.
//   cur_x/cur_y : current router coordinates
//   destport    : port taken at the current router
//   next_x/y    : coordinates of the router reached through destport
//   hop_err     : mesh hop off the edge, or destport code 5..7
//   is_local    : hop resolves as LOCAL (LOCAL or illegal code)
// On a mesh edge error the coordinates hold cur; a torus wraps instead.
module mesh_torus_next_hop
  import mesh_torus_lkh_route_pipe_pkg::*;
#(
  parameter int NX   = 4,
  parameter int NY   = 4,
  parameter int TOPO = TOPO_MESH,
  parameter int RXw  = log2(NX),
  parameter int RYw  = log2(NY)
) (
  input  logic [RXw-1:0] cur_x,
  input  logic [RYw-1:0] cur_y,
  input  logic [2:0]     destport,
  output logic [RXw-1:0] next_x,
  output logic [RYw-1:0] next_y,
  output logic           hop_err,
  output logic           is_local
);

  always_comb begin
    next_x   = cur_x;
    next_y   = cur_y;
    hop_err  = 1'b0;
    is_local = 1'b0;
    case (destport)
      PORT_LOCAL: is_local = 1'b1;
      PORT_EAST: begin
        if (int'(cur_x) == NX - 1) begin
          if (TOPO == TOPO_TORUS) next_x = '0;
          else                    hop_err = 1'b1;
        end else begin
          next_x = cur_x + RXw'(1);
        end
      end
      PORT_WEST: begin
        if (cur_x == '0) begin
          if (TOPO == TOPO_TORUS) next_x = RXw'(NX - 1);
          else                    hop_err = 1'b1;
        end else begin
          next_x = cur_x - RXw'(1);
        end
      end
      PORT_NORTH: begin
        if (cur_y == '0) begin
          if (TOPO == TOPO_TORUS) next_y = RYw'(NY - 1);
          else                    hop_err = 1'b1;
        end else begin
          next_y = cur_y - RYw'(1);
        end
      end
      PORT_SOUTH: begin
        if (int'(cur_y) == NY - 1) begin
          if (TOPO == TOPO_TORUS) next_y = '0;
          else                    hop_err = 1'b1;
        end else begin
          next_y = cur_y + RYw'(1);
        end
      end
      default: begin
        hop_err  = 1'b1;
        is_local = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mesh_torus_lkh_route_pipe.sv
// mesh_torus_lkh_route_pipe: two-stage look-ahead route computation.
//   Stage 1 computes the next router coordinates (mesh_torus_next_hop).
//   Stage 2 computes the output port at that next router (lkdestport).
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready, cur_x/cur_y, dest_x/dest_y, destport : header in
//   out_valid/out_ready, next_x/next_y, lkdestport           : result out
//   err     : sticky illegal hop / out-of-range destination
//   hdr_cnt : saturating count of consumed results
// Handshake: a transfer happens on a cycle where valid and ready are both
// high. A stage loads when it is empty or its contents leave that cycle, so
// in_ready = ~s1_valid | ~s2_valid | out_ready (no path from in_valid), and
// in_ready is forced low while reset is asserted.
module mesh_torus_lkh_route_pipe
  import mesh_torus_lkh_route_pipe_pkg::*;
#(
  parameter int  NX    = 4,
  parameter int  NY    = 4,
  parameter int  TOPO  = TOPO_MESH,
  parameter int  ROUTE = ROUTE_XY,
  parameter int  CNTw  = 16,
  localparam int RXw   = log2(NX),
  localparam int RYw   = log2(NY)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RXw-1:0]  cur_x,
  input  logic [RYw-1:0]  cur_y,
  input  logic [RXw-1:0]  dest_x,
  input  logic [RYw-1:0]  dest_y,
  input  logic [2:0]      destport,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RXw-1:0]  next_x,
  output logic [RYw-1:0]  next_y,
  output logic [2:0]      lkdestport,
  output logic            err,
  output logic [CNTw-1:0] hdr_cnt
);

  // Stage 1 registers
  logic           s1_valid;
  logic [RXw-1:0] s1_next_x, s1_dest_x;
  logic [RYw-1:0] s1_next_y, s1_dest_y;
  logic           s1_local, s1_dest_bad, s1_err;

  logic [RXw-1:0] hop_x;
  logic [RYw-1:0] hop_y;
  logic           hop_err, hop_local, dest_bad;
  logic           s1_ready, s2_ready;
  logic [2:0]     lk_d;
  logic           x_eq, y_eq, x_fwd, y_fwd;

  mesh_torus_next_hop #(
    .NX(NX), .NY(NY), .TOPO(TOPO), .RXw(RXw), .RYw(RYw)
  ) u_next_hop (
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .destport (destport),
    .next_x   (hop_x),
    .next_y   (hop_y),
    .hop_err  (hop_err),
    .is_local (hop_local)
  );

  // Non power-of-two dimensions leave unused coordinate codes.
  assign dest_bad = (int'(dest_x) >= NX) || (int'(dest_y) >= NY);

  assign s2_ready = ~out_valid | out_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_ready = reset & s1_ready;

  // Forward means EAST for X and SOUTH for Y. On a torus take the shorter
  // way around; an exact half-ring tie goes forward.
  function automatic logic go_fwd(input int dst, input int nxt, input int n);
    int d;
    if (TOPO == TOPO_TORUS) begin
      d = (dst - nxt + n) % n;
      return d <= n / 2;
    end
    return dst > nxt;
  endfunction

  always_comb begin
    lk_d  = PORT_LOCAL;
    x_eq  = (s1_next_x == s1_dest_x);
    y_eq  = (s1_next_y == s1_dest_y);
    x_fwd = go_fwd(int'(s1_dest_x), int'(s1_next_x), NX);
    y_fwd = go_fwd(int'(s1_dest_y), int'(s1_next_y), NY);
    if (!(s1_local || s1_dest_bad || (x_eq && y_eq))) begin
      if (ROUTE == ROUTE_YX) begin
        if (!y_eq) lk_d = y_fwd ? PORT_SOUTH : PORT_NORTH;
        else       lk_d = x_fwd ? PORT_EAST  : PORT_WEST;
      end else begin
        if (!x_eq) lk_d = x_fwd ? PORT_EAST  : PORT_WEST;
        else       lk_d = y_fwd ? PORT_SOUTH : PORT_NORTH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_next_x   <= '0;
      s1_next_y   <= '0;
      s1_dest_x   <= '0;
      s1_dest_y   <= '0;
      s1_local    <= 1'b0;
      s1_dest_bad <= 1'b0;
      s1_err      <= 1'b0;
      out_valid   <= 1'b0;
      next_x      <= '0;
      next_y      <= '0;
      lkdestport  <= PORT_LOCAL;
      err         <= 1'b0;
      hdr_cnt     <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_next_x   <= hop_x;
          s1_next_y   <= hop_y;
          s1_dest_x   <= dest_x;
          s1_dest_y   <= dest_y;
          s1_local    <= hop_local;
          s1_dest_bad <= dest_bad;
          s1_err      <= hop_err | dest_bad;
        end
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          next_x     <= s1_next_x;
          next_y     <= s1_next_y;
          lkdestport <= lk_d;
          err        <= err | s1_err;
        end
      end
      if (out_valid && out_ready && (hdr_cnt != '1)) begin
        hdr_cnt <= hdr_cnt + CNTw'(1);
      end
    end
  end

endmodule

// File: tb/tb_mesh_torus_lkh_route_pipe.sv
// Directed bench for mesh_torus_lkh_route_pipe. Three instances share one
// stimulus stream: mesh XY, torus XY, and torus YX with a 3-bit counter.
module tb_mesh_torus_lkh_route_pipe;
  import mesh_torus_lkh_route_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic [1:0] cur_x, cur_y, dest_x, dest_y;
  logic [2:0] destport;

  logic        m_in_ready, m_out_valid, m_err;
  logic [1:0]  m_next_x, m_next_y;
  logic [2:0]  m_lk;
  logic [15:0] m_hdr_cnt;
  logic        t_in_ready, t_out_valid, t_err;
  logic [1:0]  t_next_x, t_next_y;
  logic [2:0]  t_lk;
  logic [15:0] t_hdr_cnt;
  logic        y_in_ready, y_out_valid, y_err;
  logic [1:0]  y_next_x, y_next_y;
  logic [2:0]  y_lk;
  logic [2:0]  y_hdr_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  mesh_torus_lkh_route_pipe #(.NX(4), .NY(4), .TOPO(0), .ROUTE(0), .CNTw(16)) u_mesh (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .cur_x(cur_x), .cur_y(cur_y), .dest_x(dest_x), .dest_y(dest_y), .destport(destport),
    .out_valid(m_out_valid), .out_ready(out_ready), .next_x(m_next_x), .next_y(m_next_y),
    .lkdestport(m_lk), .err(m_err), .hdr_cnt(m_hdr_cnt));

  mesh_torus_lkh_route_pipe #(.NX(4), .NY(4), .TOPO(1), .ROUTE(0), .CNTw(16)) u_torus (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t_in_ready),
    .cur_x(cur_x), .cur_y(cur_y), .dest_x(dest_x), .dest_y(dest_y), .destport(destport),
    .out_valid(t_out_valid), .out_ready(out_ready), .next_x(t_next_x), .next_y(t_next_y),
    .lkdestport(t_lk), .err(t_err), .hdr_cnt(t_hdr_cnt));

  mesh_torus_lkh_route_pipe #(.NX(4), .NY(4), .TOPO(1), .ROUTE(1), .CNTw(3)) u_torus_yx (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(y_in_ready),
    .cur_x(cur_x), .cur_y(cur_y), .dest_x(dest_x), .dest_y(dest_y), .destport(destport),
    .out_valid(y_out_valid), .out_ready(out_ready), .next_x(y_next_x), .next_y(y_next_y),
    .lkdestport(y_lk), .err(y_err), .hdr_cnt(y_hdr_cnt));

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Present a header at a negedge and return just after the posedge that takes it.
  task automatic send(input logic [1:0] cx, input logic [1:0] cy,
                      input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] dp);
    int waits;
    waits = 0;
    @(negedge clk);
    cur_x = cx; cur_y = cy; dest_x = dx; dest_y = dy; destport = dp; in_valid = 1'b1;
    while (!m_in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!m_in_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: in_ready got %b required 1", m_in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, m_next_x, m_next_y, m_lk, m_err, m_hdr_cnt} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h required 0",
               {m_out_valid, m_next_x, m_next_y, m_lk, m_err, m_hdr_cnt});
    end
    tests_run++;
    if (m_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b required 0", m_in_ready);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (m_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_in_ready: got %b required 1", m_in_ready);
    end
  endtask

  task automatic test_mesh_basic();
    do_reset();
    out_ready = 1'b1;
    send(2'd1, 2'd1, 2'd3, 2'd0, PORT_EAST);
    idle();
    tests_run++;
    if (m_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mesh_latency_t1: out_valid got %b required 0", m_out_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, m_next_x, m_next_y, m_lk} !== {1'b1, 2'd2, 2'd1, PORT_EAST}) begin
      tests_failed++;
      $display("FAIL mesh_xy_result: got %h required %h",
               {m_out_valid, m_next_x, m_next_y, m_lk}, {1'b1, 2'd2, 2'd1, PORT_EAST});
    end
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, m_hdr_cnt} !== {1'b0, 16'd1}) begin
      tests_failed++;
      $display("FAIL mesh_drain_count: got %h required %h", {m_out_valid, m_hdr_cnt}, {1'b0, 16'd1});
    end
  endtask

  task automatic test_torus();
    do_reset();
    out_ready = 1'b1;
    send(2'd3, 2'd2, 2'd2, 2'd2, PORT_EAST);  // wrap to (0,2), X tie -> EAST
    send(2'd3, 2'd2, 2'd0, 2'd1, PORT_EAST);  // (0,2), Y distance 3 -> NORTH
    idle();
    tests_run++;
    if ({t_out_valid, t_next_x, t_next_y, t_lk} !== {1'b1, 2'd0, 2'd2, PORT_EAST}) begin
      tests_failed++;
      $display("FAIL torus_xy_tie: got %h required %h",
               {t_out_valid, t_next_x, t_next_y, t_lk}, {1'b1, 2'd0, 2'd2, PORT_EAST});
    end
    tests_run++;
    if ({y_out_valid, y_next_x, y_next_y, y_lk} !== {1'b1, 2'd0, 2'd2, PORT_EAST}) begin
      tests_failed++;
      $display("FAIL torus_yx_xonly: got %h required %h",
               {y_out_valid, y_next_x, y_next_y, y_lk}, {1'b1, 2'd0, 2'd2, PORT_EAST});
    end
    @(negedge clk);
    tests_run++;
    if ({t_out_valid, t_next_x, t_next_y, t_lk} !== {1'b1, 2'd0, 2'd2, PORT_NORTH}) begin
      tests_failed++;
      $display("FAIL torus_xy_north: got %h required %h",
               {t_out_valid, t_next_x, t_next_y, t_lk}, {1'b1, 2'd0, 2'd2, PORT_NORTH});
    end
    tests_run++;
    if ({y_out_valid, y_next_x, y_next_y, y_lk} !== {1'b1, 2'd0, 2'd2, PORT_NORTH}) begin
      tests_failed++;
      $display("FAIL torus_yx_north: got %h required %h",
               {y_out_valid, y_next_x, y_next_y, y_lk}, {1'b1, 2'd0, 2'd2, PORT_NORTH});
    end
    send(2'd0, 2'd0, 2'd3, 2'd3, PORT_WEST);  // wrap to (3,0); Y distance 3 -> NORTH
    idle();
    @(negedge clk);
    tests_run++;
    if ({t_out_valid, t_next_x, t_next_y, t_lk} !== {1'b1, 2'd3, 2'd0, PORT_NORTH}) begin
      tests_failed++;
      $display("FAIL torus_west_wrap: got %h required %h",
               {t_out_valid, t_next_x, t_next_y, t_lk}, {1'b1, 2'd3, 2'd0, PORT_NORTH});
    end
    tests_run++;
    if ({t_err, m_err} !== 2'b01) begin
      tests_failed++;
      $display("FAIL torus_vs_mesh_err: got %b required 01", {t_err, m_err});
    end
  endtask

  task automatic test_mesh_edge();
    do_reset();
    out_ready = 1'b1;
    send(2'd3, 2'd0, 2'd0, 2'd0, PORT_EAST);
    idle();
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, m_next_x, m_next_y, m_lk, m_err} !== {1'b1, 2'd3, 2'd0, PORT_WEST, 1'b1}) begin
      tests_failed++;
      $display("FAIL mesh_edge: got %h required %h",
               {m_out_valid, m_next_x, m_next_y, m_lk, m_err}, {1'b1, 2'd3, 2'd0, PORT_WEST, 1'b1});
    end
    tests_run++;
    if ({t_next_x, t_next_y, t_lk} !== {2'd0, 2'd0, PORT_LOCAL}) begin
      tests_failed++;
      $display("FAIL torus_arrive_local: got %h required %h",
               {t_next_x, t_next_y, t_lk}, {2'd0, 2'd0, PORT_LOCAL});
    end
    for (int i = 0; i < 10; i++) send(2'd1, 2'd1, 2'd2, 2'd2, PORT_SOUTH);
    idle();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({m_err, t_err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b required 10", {m_err, t_err});
    end
    send(2'd1, 2'd1, 2'd2, 2'd2, 3'd5);
    idle();
    @(negedge clk);
    tests_run++;
    if ({t_out_valid, t_next_x, t_next_y, t_lk, t_err} !== {1'b1, 2'd1, 2'd1, PORT_LOCAL, 1'b1}) begin
      tests_failed++;
      $display("FAIL illegal_port: got %h required %h",
               {t_out_valid, t_next_x, t_next_y, t_lk, t_err}, {1'b1, 2'd1, 2'd1, PORT_LOCAL, 1'b1});
    end
  endtask

  task automatic test_backpressure();
    int got;
    logic [6:0] snap;
    logic have_snap;
    do_reset();
    out_ready = 1'b0;
    exp_q.delete();
    // cur (i%4, i/4) SOUTH toward (3,3): EAST until x==3, then SOUTH.
    for (int i = 0; i < 8; i++)
      exp_q.push_back({2'(i % 4), 2'(i / 4 + 1), ((i % 4) == 3) ? PORT_SOUTH : PORT_EAST});
    got = 0; have_snap = 1'b0; snap = '0;
    fork
      begin
        send(2'd0, 2'd0, 2'd3, 2'd3, PORT_SOUTH);
        send(2'd1, 2'd0, 2'd3, 2'd3, PORT_SOUTH);
        @(negedge clk);
        tests_run++;
        if (m_in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_in_ready: got %b required 0", m_in_ready);
        end
        for (int i = 2; i < 8; i++) send(2'(i % 4), 2'(i / 4), 2'd3, 2'd3, PORT_SOUTH);
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 200 && got < 8; c++) begin
          @(negedge clk);
          if (m_out_valid && !out_ready) begin
            if (have_snap) begin
              tests_run++;
              if ({m_next_x, m_next_y, m_lk} !== snap) begin
                tests_failed++;
                $display("FAIL stall_hold: got %h required %h", {m_next_x, m_next_y, m_lk}, snap);
              end
            end else begin
              snap = exp_q[0];
              have_snap = 1'b1;
            end
          end
          if (m_out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
              tests_failed++;
              $display("FAIL bp_extra: got %h required none", {m_next_x, m_next_y, m_lk});
            end else if ({m_next_x, m_next_y, m_lk} !== exp_q[0]) begin
              tests_failed++;
              $display("FAIL bp_data%0d: got %h required %h", got, {m_next_x, m_next_y, m_lk}, exp_q[0]);
              void'(exp_q.pop_front());
            end else begin
              void'(exp_q.pop_front());
            end
            got++;
          end
        end
        if (got < 8) begin
          tests_run++; tests_failed++;
          $display("FAIL bp_timeout: got %0d results required 8", got);
        end
      end
    join
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, m_hdr_cnt} !== {1'b0, 16'd8} || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_count: got valid=%b cnt=%0d left=%0d required valid=0 cnt=8 left=0",
               m_out_valid, m_hdr_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b1;
    send(2'd3, 2'd0, 2'd0, 2'd0, PORT_EAST);  // mesh edge error
    send(2'd1, 2'd1, 2'd2, 2'd2, PORT_EAST);
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, m_err} !== 2'b11) begin
      tests_failed++;
      $display("FAIL midstream_pre: got %b required 11", {m_out_valid, m_err});
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({m_out_valid, m_err, m_hdr_cnt} !== 18'd0) begin
      tests_failed++;
      $display("FAIL midstream_reset: got %h required 0", {m_out_valid, m_err, m_hdr_cnt});
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (m_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midstream_in_ready: got %b required 1", m_in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (m_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midstream_discard: out_valid got %b required 0", m_out_valid);
    end
  endtask

  task automatic test_back_to_back_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(2'd1, 2'd1, 2'd2, 2'd2, PORT_EAST);
    idle();
    repeat (4) @(negedge clk);
    tests_run++;
    if (y_hdr_cnt !== 3'd7) begin
      tests_failed++;
      $display("FAIL sat_count: got %0d required 7", y_hdr_cnt);
    end
    tests_run++;
    if (m_hdr_cnt !== 16'd10) begin
      tests_failed++;
      $display("FAIL wide_count: got %0d required 10", m_hdr_cnt);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur_x = '0; cur_y = '0; dest_x = '0; dest_y = '0; destport = PORT_LOCAL;
    repeat (2) @(negedge clk);
    test_reset();
    test_mesh_basic();
    test_torus();
    test_mesh_edge();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
